seg_scan_arbiter: RTL and testbench
===================================

Name: seg_scan_arbiter

Overview:
- Time-multiplexed scan controller for the board's 8-digit seven-segment display.
- Shares the display between two requesters:
  - the clock core's time/edit digits (default source);
  - a message buffer loaded from the UART receive path (timed override).
- Switches source only on frame boundaries, applies edit-mode blinking and anti-ghost blanking, and drives registered anode and segment lines.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz).
- DIGITS, 8, number of digits scanned.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off.
- MSG_HOLD, 2000, frames a message stays displayed after a load.
- BLINK_FRAMES, 62, frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- time_bcd  in  4*DIGITS  clock-core digits; nibble i = digit i, digit 0 rightmost
- dp_mask  in  DIGITS  decimal-point enables for the time source
- blink_mask  in  DIGITS  digits to blink (edit mode), time source only
- msg_load  in  1  single-cycle pulse: capture msg_data and start the override
- msg_data  in  4*DIGITS  hex nibbles for the message; value 4'hF on msg_blank bit blanks the digit
- msg_blank  in  DIGITS  per-digit blank for the message
- an  out  DIGITS  anodes, active-low, one-hot-low while a digit is lit
- seg  out  8  active-low; seg[6:0]=g..a, seg[7]=dp
- src_msg  out  1  1 while the current frame shows the message

Behaviour:
- Reset (async, rst=1):
  - an = all 1; seg = 8'hFF; src_msg = 0.
  - Prescaler, digit index, hold counter and blink phase = 0.
  - Frame buffer cleared to blank.
  - Internal start flag set.
- Prescaler: counts 0..SCAN_DIV-1. tick = (cnt == SCAN_DIV-1). Digit index advances on tick and wraps DIGITS-1 -> 0.
- Frame start (fs) occurs on either:
  - a tick with index DIGITS-1; or
  - the first edge after reset release (start flag, which then clears).
- At fs:
  - src = (hold_cnt != 0).
  - Frame buffer latches the selected source: time_bcd/dp_mask/blink_mask, or the msg buffer (dp off, blink off).
  - src_msg updates to src.
- Frame latch samples register values before the edge. A msg_load in the same cycle as fs takes effect at the next fs.
- msg_load:
  - Captures msg_data/msg_blank into the msg buffer.
  - hold_cnt <= MSG_HOLD.
  - A reload while the override is active replaces the data and restarts the hold; no gap.
- hold_cnt: decrements by 1 at each fs when nonzero and msg_load is not asserted; load wins over decrement. Time returns at the first fs after hold_cnt reaches 0.
- Blink: frame counter toggles blink phase every BLINK_FRAMES frames. When phase = 1, digits with a latched blink bit display blank (dp also off).
- Digit output:
  - Registered, 1-cycle latency from the index/prescaler state.
  - During slot cycles 0..BLANK_CYC-1: an = all 1 and seg = 8'hFF.
  - Otherwise an[index] = 0, others 1; seg = decode(nibble) & dp.
  - BLANK_CYC >= SCAN_DIV is illegal (elaboration assertion).
- Decode (hex to active-low g..a):
  - 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - blank = 7'h7F.
- Input changes mid-frame never alter the displayed frame (no tearing).
- Reset mid-frame returns everything to reset values immediately; outputs go blank asynchronously.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK (8'hFF).
  - Hex-to-segment constant table.
  - Digit-nibble width constant.
- Sub-module seg_hex_decode: combinational, 4-bit nibble + blank -> 7-bit active-low pattern. Shared by future display blocks.

Test Plan:
All scenarios use SCAN_DIV=4, DIGITS=8, BLANK_CYC=1, MSG_HOLD=2, BLINK_FRAMES=1.
- Reset / first frame:
  - Stimulus: hold rst, release with time_bcd=32'h12345678.
  - Response: an=8'hFF and seg=8'hFF during reset. After release, an=8'hFE, seg=7'h00 pattern for digit 0 ("8", dp off), following the 1-cycle blank slot.
- Scan order:
  - Stimulus: free run for one frame.
  - Response: an walks FE, FD, ..., 7F, each digit lit 3 of 4 cycles. Digits show 8,7,6,5,4,3,2,1. Frame length 32 cycles.
- Tear-free switching:
  - Stimulus: change time_bcd mid-frame to 32'h00000000.
  - Response: remaining digits of the current frame still show old values; zeros (7'h40) appear from the next frame.
- Message override and expiry:
  - Stimulus: pulse msg_load with msg_data=32'hC0FFEE00.
  - Response: from the next fs, src_msg=1 and digits show the message. Exactly 2 message frames are shown, then src_msg=0 and time returns.
- Reload and fs collision:
  - Stimulus: msg_load coincident with fs; a second msg_load during the override.
  - Response: the coincident load takes effect one frame later. The second load restarts the 2-frame hold with the new data, with no time frame shown in between.
- Blink:
  - Stimulus: blink_mask=8'h03.
  - Response: digits 0–1 alternate lit and blank every frame; digits 2–7 are always lit. During the override, blink_mask is ignored.

Source files
------------

// File: rtl/seg_pkg.sv
// Seven-segment constants shared by the display blocks: blank code, nibble width, hex glyph table.
// Glyphs are active-low in g..a order; the decimal point is handled by each user.
package seg_pkg;
  localparam int NIB_W = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index = hex value; element 15 is listed first.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low g..a segment pattern, with a blank override.
// Purely combinational; no flow control.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic             blank,
  output logic [6:0]       seg_n
);
  assign seg_n = blank ? SEG_OFF : SEG_HEX[nib];
endmodule

// File: rtl/seg_scan_arbiter.sv
// Scans an 8-digit display from either the clock-core digits or a timed message override.
// Outputs are registered one cycle behind the scan state; source swaps only at frame boundaries.
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DIGITS       = 8,
  parameter int BLANK_CYC    = 2,
  parameter int MSG_HOLD     = 2000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NIB_W*DIGITS-1:0]   time_bcd,
  input  logic [DIGITS-1:0]         dp_mask,
  input  logic [DIGITS-1:0]         blink_mask,
  input  logic                      msg_load,
  input  logic [NIB_W*DIGITS-1:0]   msg_data,
  input  logic [DIGITS-1:0]         msg_blank,
  output logic [DIGITS-1:0]         an,
  output logic [7:0]                seg,
  output logic                      src_msg
);
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HOLD_W = $clog2(MSG_HOLD + 1);
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MSG_HOLD);
  localparam logic [BLK_W-1:0]  BLK_MAX   = BLK_W'(BLINK_FRAMES - 1);

  if (BLANK_CYC >= SCAN_DIV) begin : g_cfg_check
    $error("seg_scan_arbiter: BLANK_CYC must be smaller than SCAN_DIV");
  end

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           start_q, start_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;
  logic [BLK_W-1:0]               blink_cnt_q, blink_cnt_d;
  logic                           blink_ph_q, blink_ph_d;
  logic [DIGITS-1:0][NIB_W-1:0]   msg_nib_q, msg_nib_d;
  logic [DIGITS-1:0]              msg_blank_q, msg_blank_d;
  logic [DIGITS-1:0][NIB_W-1:0]   fb_nib_q, fb_nib_d;
  logic [DIGITS-1:0]              fb_dp_q, fb_dp_d;
  logic [DIGITS-1:0]              fb_blink_q, fb_blink_d;
  logic [DIGITS-1:0]              fb_off_q, fb_off_d;
  logic                           src_msg_q, src_msg_d;
  logic [DIGITS-1:0]              an_q, an_d;
  logic [7:0]                     seg_q, seg_d;

  logic                           tick, fs;
  logic                           cur_off, cur_dp;
  logic [6:0]                     dec_seg;

  seg_hex_decode u_dec (
    .nib   (fb_nib_q[idx_q]),
    .blank (cur_off),
    .seg_n (dec_seg)
  );

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    start_d     = 1'b0;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    msg_nib_d   = msg_nib_q;
    msg_blank_d = msg_blank_q;
    fb_nib_d    = fb_nib_q;
    fb_dp_d     = fb_dp_q;
    fb_blink_d  = fb_blink_q;
    fb_off_d    = fb_off_q;
    src_msg_d   = src_msg_q;
    an_d        = '1;
    seg_d       = SEG_BLANK;

    tick = (cnt_q == CNT_MAX);
    fs   = start_q || (tick && (idx_q == IDX_MAX));

    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A load outranks the frame-boundary decrement so a reload always restarts the full hold.
    if (msg_load) begin
      msg_nib_d   = msg_data;
      msg_blank_d = msg_blank;
      hold_d      = HOLD_INIT;
    end else if (fs && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    if (fs) begin
      src_msg_d = (hold_q != '0);
      if (hold_q != '0) begin
        fb_nib_d   = msg_nib_q;
        fb_dp_d    = '0;
        fb_blink_d = '0;
        fb_off_d   = msg_blank_q;
      end else begin
        fb_nib_d   = time_bcd;
        fb_dp_d    = dp_mask;
        fb_blink_d = blink_mask;
        fb_off_d   = '0;
      end
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    cur_off = fb_off_q[idx_q] | (fb_blink_q[idx_q] & blink_ph_q);
    cur_dp  = fb_dp_q[idx_q] & ~cur_off;
    // Leading cycles of each slot keep every anode off so the previous digit cannot ghost.
    if (cnt_q >= BLANK_END) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = {~cur_dp, dec_seg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      start_q     <= 1'b1;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      msg_nib_q   <= '0;
      msg_blank_q <= '1;
      fb_nib_q    <= '0;
      fb_dp_q     <= '0;
      fb_blink_q  <= '0;
      fb_off_q    <= '1;
      src_msg_q   <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      msg_nib_q   <= msg_nib_d;
      msg_blank_q <= msg_blank_d;
      fb_nib_q    <= fb_nib_d;
      fb_dp_q     <= fb_dp_d;
      fb_blink_q  <= fb_blink_d;
      fb_off_q    <= fb_off_d;
      src_msg_q   <= src_msg_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign src_msg = src_msg_q;
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with a 4-cycle slot, 8 digits and 32-cycle frames.
// Frames are walked cycle by cycle against hand-derived anode/segment expectations.
module tb_seg_scan_arbiter;
  logic        clk;
  logic        rst;
  logic [31:0] time_bcd;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic        msg_load;
  logic [31:0] msg_data;
  logic [7:0]  msg_blank;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        src_msg;

  int n_cmp = 0;
  int n_err = 0;
  int fr    = 0;

  seg_scan_arbiter #(
    .SCAN_DIV(4), .DIGITS(8), .BLANK_CYC(1), .MSG_HOLD(2), .BLINK_FRAMES(1)
  ) dut (
    .clk(clk), .rst(rst), .time_bcd(time_bcd), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .msg_load(msg_load), .msg_data(msg_data),
    .msg_blank(msg_blank), .an(an), .seg(seg), .src_msg(src_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] exp_an(input int p);
    if (p % 4 == 0) return 8'hFF;
    return ~(8'h01 << (p / 4));
  endfunction

  function automatic logic [7:0] exp_seg(input int p, input logic [31:0] nib,
                                         input logic [7:0] bl, input logic [7:0] dp);
    int d;
    d = p / 4;
    if (p % 4 == 0 || bl[d]) return 8'hFF;
    return {~dp[d], hex7(nib[d*4 +: 4])};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an an=%h want ff", an); end
    n_cmp++;
    if (seg !== 8'hFF) begin n_err++; $display("FAIL reset_seg seg=%h want ff", seg); end
    n_cmp++;
    if (src_msg !== 1'b0) begin n_err++; $display("FAIL reset_src src=%b want 0", src_msg); end
    rst = 1'b0;
    fr++;
    for (int p = 0; p < 32; p++) begin
      step();
      n_cmp++;
      if (an !== exp_an(p)) begin n_err++; $display("FAIL first_an f%0d p%0d an=%h want %h", fr, p, an, exp_an(p)); end
      n_cmp++;
      if (seg !== exp_seg(p, 32'h12345678, 8'h00, 8'h00)) begin
        n_err++; $display("FAIL first_seg f%0d p%0d seg=%h want %h", fr, p, seg, exp_seg(p, 32'h12345678, 8'h00, 8'h00));
      end
      if (p == 1) begin
        n_cmp++;
        if (src_msg !== 1'b0) begin n_err++; $display("FAIL first_src f%0d src=%b want 0", fr, src_msg); end
      end
    end
  endtask

  task automatic test_scan_order();
    fr++;
    for (int p = 0; p < 32; p++) begin
      step();
      n_cmp++;
      if (an !== exp_an(p)) begin n_err++; $display("FAIL scan_an f%0d p%0d an=%h want %h", fr, p, an, exp_an(p)); end
      n_cmp++;
      if (seg !== exp_seg(p, 32'h12345678, 8'h00, 8'h00)) begin
        n_err++; $display("FAIL scan_seg f%0d p%0d seg=%h want %h", fr, p, seg, exp_seg(p, 32'h12345678, 8'h00, 8'h00));
      end
      if (p == 10) dp_mask = 8'h81;
    end
  endtask

  task automatic test_tear_free();
    logic [31:0] nib [2] = '{32'h12345678, 32'h00000000};
    for (int i = 0; i < 2; i++) begin
      fr++;
      for (int p = 0; p < 32; p++) begin
        step();
        n_cmp++;
        if (an !== exp_an(p)) begin n_err++; $display("FAIL tear_an f%0d p%0d an=%h want %h", fr, p, an, exp_an(p)); end
        n_cmp++;
        if (seg !== exp_seg(p, nib[i], 8'h00, 8'h81)) begin
          n_err++; $display("FAIL tear_seg f%0d p%0d seg=%h want %h", fr, p, seg, exp_seg(p, nib[i], 8'h00, 8'h81));
        end
        if (i == 0 && p == 12) time_bcd = 32'h00000000;
        if (i == 1 && p == 20) dp_mask = 8'h00;
      end
    end
  endtask

  task automatic test_msg_override();
    logic [31:0] nib [4] = '{32'h00000000, 32'hC0FFEE00, 32'hC0FFEE00, 32'h9ABCDEF0};
    logic [7:0]  dp  [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    logic        src [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      fr++;
      for (int p = 0; p < 32; p++) begin
        step();
        n_cmp++;
        if (an !== exp_an(p)) begin n_err++; $display("FAIL msg_an f%0d p%0d an=%h want %h", fr, p, an, exp_an(p)); end
        n_cmp++;
        if (seg !== exp_seg(p, nib[i], 8'h00, dp[i])) begin
          n_err++; $display("FAIL msg_seg f%0d p%0d seg=%h want %h", fr, p, seg, exp_seg(p, nib[i], 8'h00, dp[i]));
        end
        if (p == 1) begin
          n_cmp++;
          if (src_msg !== src[i]) begin n_err++; $display("FAIL msg_src f%0d src=%b want %b", fr, src_msg, src[i]); end
        end
        msg_load = 1'b0;
        if (i == 0 && p == 8) begin msg_data = 32'hC0FFEE00; msg_blank = 8'h00; msg_load = 1'b1; end
        if (i == 1 && p == 3) dp_mask = 8'hFF;
        if (i == 2 && p == 3) time_bcd = 32'h9ABCDEF0;
      end
    end
  endtask

  task automatic test_reload_collision();
    logic [31:0] nib [6] = '{32'h9ABCDEF0, 32'h9ABCDEF0, 32'h13579BDF, 32'h2468ACE0, 32'h2468ACE0, 32'h9ABCDEF0};
    logic [7:0]  bl  [6] = '{8'h00, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00};
    logic [7:0]  dp  [6] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic        src [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      fr++;
      for (int p = 0; p < 32; p++) begin
        step();
        n_cmp++;
        if (an !== exp_an(p)) begin n_err++; $display("FAIL reload_an f%0d p%0d an=%h want %h", fr, p, an, exp_an(p)); end
        n_cmp++;
        if (seg !== exp_seg(p, nib[i], bl[i], dp[i])) begin
          n_err++; $display("FAIL reload_seg f%0d p%0d seg=%h want %h", fr, p, seg, exp_seg(p, nib[i], bl[i], dp[i]));
        end
        if (p == 1) begin
          n_cmp++;
          if (src_msg !== src[i]) begin n_err++; $display("FAIL reload_src f%0d src=%b want %b", fr, src_msg, src[i]); end
        end
        msg_load = 1'b0;
        if (i == 0 && p == 30) begin msg_data = 32'h13579BDF; msg_blank = 8'hF0; msg_load = 1'b1; end
        if (i == 1 && p == 5) dp_mask = 8'h00;
        if (i == 2 && p == 16) begin msg_data = 32'h2468ACE0; msg_blank = 8'h00; msg_load = 1'b1; end
        if (i == 4 && p == 4) blink_mask = 8'h03;
      end
    end
  endtask

  task automatic test_blink();
    logic [31:0] nib [6] = '{32'h9ABCDEF0, 32'h9ABCDEF0, 32'h55555555, 32'h55555555, 32'h9ABCDEF0, 32'h9ABCDEF0};
    logic [7:0]  bl  [6] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    logic        src [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      fr++;
      for (int p = 0; p < 32; p++) begin
        step();
        n_cmp++;
        if (an !== exp_an(p)) begin n_err++; $display("FAIL blink_an f%0d p%0d an=%h want %h", fr, p, an, exp_an(p)); end
        n_cmp++;
        if (seg !== exp_seg(p, nib[i], bl[i], 8'h00)) begin
          n_err++; $display("FAIL blink_seg f%0d p%0d seg=%h want %h", fr, p, seg, exp_seg(p, nib[i], bl[i], 8'h00));
        end
        if (p == 1) begin
          n_cmp++;
          if (src_msg !== src[i]) begin n_err++; $display("FAIL blink_src f%0d src=%b want %b", fr, src_msg, src[i]); end
        end
        msg_load = 1'b0;
        if (i == 1 && p == 4) begin msg_data = 32'h55555555; msg_blank = 8'h00; msg_load = 1'b1; end
      end
    end
  endtask

  task automatic test_reset_midframe();
    repeat (10) step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (an !== 8'hFF) begin n_err++; $display("FAIL midrst_an an=%h want ff", an); end
    n_cmp++;
    if (seg !== 8'hFF) begin n_err++; $display("FAIL midrst_seg seg=%h want ff", seg); end
    n_cmp++;
    if (src_msg !== 1'b0) begin n_err++; $display("FAIL midrst_src src=%b want 0", src_msg); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fr = 1;
    for (int p = 0; p < 32; p++) begin
      step();
      n_cmp++;
      if (an !== exp_an(p)) begin n_err++; $display("FAIL midrst_f1_an p%0d an=%h want %h", p, an, exp_an(p)); end
      n_cmp++;
      if (seg !== exp_seg(p, 32'h9ABCDEF0, 8'h03, 8'h00)) begin
        n_err++; $display("FAIL midrst_f1_seg p%0d seg=%h want %h", p, seg, exp_seg(p, 32'h9ABCDEF0, 8'h03, 8'h00));
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    time_bcd   = 32'h12345678;
    dp_mask    = 8'h00;
    blink_mask = 8'h00;
    msg_load   = 1'b0;
    msg_data   = 32'h0;
    msg_blank  = 8'h00;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_msg_override();
    test_reload_collision();
    test_blink();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
